execute_pipe: RTL and testbench

- Registered, parametrised execute stage for the Nios II-style pipeline; sits between decode/register-read and memory.
- Extends the combinational execute stage with: configurable data/register width, valid/ready handshakes, a multi-cycle multiply with a busy FSM, and branch resolution.
- Adds pipeline flush and illegal-opcode flagging.
- Opcode encodings are unchanged: ADD 110001, LDW 010111, MUL 100111, BLT 010110, STW 010101, BR 000110, ADDI 000100, BEQ 100110, BNE 011110, JMP 111010, CALL 000000, SUBI 011111, NOPE 111111.

---
 rtl/execute_pipe.sv | 173 +++++++++++++++++
 tb/tb_execute_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_pipe.sv
// execute_pipe: registered execute stage sitting between decode/register-read
// and memory. Single-cycle ALU/branch ops load the output register on the
// accept edge; MUL (when MUL_LAT>1) parks the stage in MUL_BUSY until its
// result lands exactly MUL_LAT cycles after accept. Flush drops any pending
// result and aborts an in-flight multiply.
//
// Ports:
//   clk_40, rst_n_40        clock (rising edge), async active-low reset
//   flush_40                synchronous pipeline flush
//   in_valid_40/in_ready_40 input handshake
//   opcode_40, a_40, b_40, sign_ext_40, src/dest/targ_reg_40   operation in
//   out_valid_40/out_ready_40   output handshake
//   alu_out_40, alu_src_40, opcode_out_40, src/dest/targ_reg_out_40  result
//   branch_taken_40, illegal_op_40   control-transfer / illegal-opcode flags
module execute_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 6,
  parameter int MUL_LAT = 4
) (
  input  logic              clk_40,
  input  logic              rst_n_40,
  input  logic              flush_40,
  input  logic              in_valid_40,
  output logic              in_ready_40,
  input  logic [5:0]        opcode_40,
  input  logic [DATA_W-1:0] a_40,
  input  logic [DATA_W-1:0] b_40,
  input  logic [DATA_W-1:0] sign_ext_40,
  input  logic [REG_W-1:0]  src_reg_40,
  input  logic [REG_W-1:0]  dest_reg_40,
  input  logic [REG_W-1:0]  targ_reg_40,
  output logic              out_valid_40,
  input  logic              out_ready_40,
  output logic [DATA_W-1:0] alu_out_40,
  output logic [DATA_W-1:0] alu_src_40,
  output logic [5:0]        opcode_out_40,
  output logic [REG_W-1:0]  src_reg_out_40,
  output logic [REG_W-1:0]  dest_reg_out_40,
  output logic [REG_W-1:0]  targ_reg_out_40,
  output logic              branch_taken_40,
  output logic              illegal_op_40
);

  localparam logic [5:0] OP_ADD  = 6'b110001;
  localparam logic [5:0] OP_LDW  = 6'b010111;
  localparam logic [5:0] OP_MUL  = 6'b100111;
  localparam logic [5:0] OP_BLT  = 6'b010110;
  localparam logic [5:0] OP_STW  = 6'b010101;
  localparam logic [5:0] OP_BR   = 6'b000110;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_BEQ  = 6'b100110;
  localparam logic [5:0] OP_BNE  = 6'b011110;
  localparam logic [5:0] OP_JMP  = 6'b111010;
  localparam logic [5:0] OP_CALL = 6'b000000;
  localparam logic [5:0] OP_SUBI = 6'b011111;
  localparam logic [5:0] OP_NOPE = 6'b111111;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  // Counter only ever holds MUL_LAT-1 .. 1
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mul_a, mul_b;
  logic [REG_W-1:0]  mul_src, mul_dst, mul_targ;

  logic              accept, mul_multi;
  logic [DATA_W-1:0] res, mul_in_lo, mul_busy_lo;
  logic              res_taken, res_illegal;

  assign in_ready_40 = rst_n_40 && (state == ST_IDLE) && !flush_40 &&
                       (!out_valid_40 || out_ready_40);
  assign accept      = in_valid_40 && in_ready_40;
  assign mul_multi   = (MUL_LAT > 1) && (opcode_40 == OP_MUL);

  // Low DATA_W bits only: the product is truncated to the assignment width
  assign mul_in_lo   = a_40 * b_40;
  assign mul_busy_lo = mul_a * mul_b;

  always_comb begin
    res         = '0;
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    case (opcode_40)
      OP_ADD:                  res = a_40 + b_40;
      OP_LDW, OP_STW, OP_ADDI: res = a_40 + sign_ext_40;
      OP_SUBI:                 res = a_40 - sign_ext_40;
      OP_MUL:                  res = mul_in_lo;
      OP_CALL: begin res = b_40;        res_taken = 1'b1; end
      OP_JMP:  begin res = a_40;        res_taken = 1'b1; end
      OP_BR:   begin res = sign_ext_40; res_taken = 1'b1; end
      OP_BEQ:  begin res = sign_ext_40; res_taken = (a_40 == b_40); end
      OP_BNE:  begin res = sign_ext_40; res_taken = (a_40 != b_40); end
      OP_BLT:  begin
        res       = sign_ext_40;
        res_taken = $signed(a_40) < $signed(b_40);
      end
      OP_NOPE:                 res = '0;
      default:                 res_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_40 or negedge rst_n_40) begin
    if (!rst_n_40) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      mul_a           <= '0;
      mul_b           <= '0;
      mul_src         <= '0;
      mul_dst         <= '0;
      mul_targ        <= '0;
      out_valid_40    <= 1'b0;
      alu_out_40      <= '0;
      alu_src_40      <= '0;
      opcode_out_40   <= '0;
      src_reg_out_40  <= '0;
      dest_reg_out_40 <= '0;
      targ_reg_out_40 <= '0;
      branch_taken_40 <= 1'b0;
      illegal_op_40   <= 1'b0;
    end else if (flush_40) begin
      // Data outputs intentionally left stale; only the qualifiers clear
      state           <= ST_IDLE;
      cnt             <= '0;
      out_valid_40    <= 1'b0;
      branch_taken_40 <= 1'b0;
      illegal_op_40   <= 1'b0;
    end else if (state == ST_MUL_BUSY) begin
      if (cnt == CNT_W'(1)) begin
        state           <= ST_IDLE;
        cnt             <= '0;
        out_valid_40    <= 1'b1;
        alu_out_40      <= mul_busy_lo;
        alu_src_40      <= mul_b;
        opcode_out_40   <= OP_MUL;
        src_reg_out_40  <= mul_src;
        dest_reg_out_40 <= mul_dst;
        targ_reg_out_40 <= mul_targ;
        branch_taken_40 <= 1'b0;
        illegal_op_40   <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else if (accept) begin
      if (mul_multi) begin
        // Accept implies the previous result is consumed on this edge
        state        <= ST_MUL_BUSY;
        cnt          <= CNT_W'(MUL_LAT - 1);
        out_valid_40 <= 1'b0;
        mul_a        <= a_40;
        mul_b        <= b_40;
        mul_src      <= src_reg_40;
        mul_dst      <= dest_reg_40;
        mul_targ     <= targ_reg_40;
      end else begin
        out_valid_40    <= 1'b1;
        alu_out_40      <= res;
        alu_src_40      <= b_40;
        opcode_out_40   <= opcode_40;
        src_reg_out_40  <= src_reg_40;
        dest_reg_out_40 <= dest_reg_40;
        targ_reg_out_40 <= targ_reg_40;
        branch_taken_40 <= res_taken;
        illegal_op_40   <= res_illegal;
      end
    end else if (out_ready_40) begin
      out_valid_40 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed cases with literal expectations, then a
// randomized phase. A transaction-level model (queue of expected results,
// MUL latency tracker) is checked against the DUT on every negedge.
module tb_execute_pipe;
  localparam int DW = 32, RW = 6, ML = 4;

  localparam logic [5:0] ADD = 6'b110001, LDW = 6'b010111, MUL = 6'b100111,
    BLT = 6'b010110, STW = 6'b010101, BR = 6'b000110, ADDI = 6'b000100,
    BEQ = 6'b100110, BNE = 6'b011110, JMP = 6'b111010, CALL = 6'b000000,
    SUBI = 6'b011111, NOPE = 6'b111111;

  logic clk_40 = 1'b0, rst_n_40 = 1'b0, flush_40 = 1'b0;
  logic in_valid_40 = 1'b0, out_ready_40 = 1'b0;
  logic [5:0] opcode_40 = '0;
  logic [DW-1:0] a_40 = '0, b_40 = '0, sign_ext_40 = '0;
  logic [RW-1:0] src_reg_40 = '0, dest_reg_40 = '0, targ_reg_40 = '0;
  logic in_ready_40, out_valid_40, branch_taken_40, illegal_op_40;
  logic [DW-1:0] alu_out_40, alu_src_40;
  logic [5:0] opcode_out_40;
  logic [RW-1:0] src_reg_out_40, dest_reg_out_40, targ_reg_out_40;

  execute_pipe #(.DATA_W(DW), .REG_W(RW), .MUL_LAT(ML)) dut (
    .clk_40(clk_40), .rst_n_40(rst_n_40), .flush_40(flush_40),
    .in_valid_40(in_valid_40), .in_ready_40(in_ready_40),
    .opcode_40(opcode_40), .a_40(a_40), .b_40(b_40), .sign_ext_40(sign_ext_40),
    .src_reg_40(src_reg_40), .dest_reg_40(dest_reg_40), .targ_reg_40(targ_reg_40),
    .out_valid_40(out_valid_40), .out_ready_40(out_ready_40),
    .alu_out_40(alu_out_40), .alu_src_40(alu_src_40), .opcode_out_40(opcode_out_40),
    .src_reg_out_40(src_reg_out_40), .dest_reg_out_40(dest_reg_out_40),
    .targ_reg_out_40(targ_reg_out_40), .branch_taken_40(branch_taken_40),
    .illegal_op_40(illegal_op_40)
  );

  always #5 clk_40 = ~clk_40;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] alu, src;
    logic [5:0]    op;
    logic [RW-1:0] s, d, t;
    logic          tk, il;
  } res_t;

  function automatic res_t ref_exec(input logic [5:0] op, input logic [DW-1:0] a, b, se,
                                    input logic [RW-1:0] s, d, t);
    res_t r;
    logic [2*DW-1:0] p;
    r.alu = '0; r.tk = 1'b0; r.il = 1'b0;
    r.src = b; r.op = op; r.s = s; r.d = d; r.t = t;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    case (op)
      ADD:            r.alu = a + b;
      LDW, STW, ADDI: r.alu = a + se;
      SUBI:           r.alu = a - se;
      MUL:            r.alu = p[DW-1:0];
      CALL: begin r.alu = b;  r.tk = 1'b1; end
      JMP:  begin r.alu = a;  r.tk = 1'b1; end
      BR:   begin r.alu = se; r.tk = 1'b1; end
      BEQ:  begin r.alu = se; r.tk = (a == b); end
      BNE:  begin r.alu = se; r.tk = (a != b); end
      BLT:  begin r.alu = se; r.tk = ($signed(a) < $signed(b)); end
      NOPE: r.alu = '0;
      default: r.il = 1'b1;
    endcase
    return r;
  endfunction

  // Model: expected results in delivery order, plus MUL-in-flight tracker
  res_t q[$];
  bit   mul_pend = 0;
  int   mul_el = 0;

  always @(negedge clk_40) begin
    if (!rst_n_40) begin
      q.delete();
      mul_pend = 0;
    end else begin
      if (mul_pend) begin
        mul_el++;
        if (mul_el < ML) chk("mul_busy_vld_rdy", {out_valid_40, in_ready_40}, 2'b00);
        else mul_pend = 0;
      end
      chk("in_ready_rule", in_ready_40,
          !mul_pend && !flush_40 && (!out_valid_40 || out_ready_40));
      chk("out_valid", out_valid_40, (q.size() > 0) && !mul_pend);
      if (out_valid_40 && q.size() > 0 && !mul_pend) begin
        chk("res_alu", alu_out_40, q[0].alu);
        chk("res_src", alu_src_40, q[0].src);
        chk("res_ctl", {opcode_out_40, src_reg_out_40, dest_reg_out_40, targ_reg_out_40,
                        branch_taken_40, illegal_op_40},
                       {q[0].op, q[0].s, q[0].d, q[0].t, q[0].tk, q[0].il});
        if (out_ready_40 && !flush_40) void'(q.pop_front());
      end
      if (flush_40) begin
        q.delete();
        mul_pend = 0;
      end
      if (in_valid_40 && in_ready_40) begin
        q.push_back(ref_exec(opcode_40, a_40, b_40, sign_ext_40,
                             src_reg_40, dest_reg_40, targ_reg_40));
        if (opcode_40 == MUL) begin
          mul_pend = 1;
          mul_el = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic send(input logic [5:0] op, input logic [DW-1:0] a, b, se);
    bit ok;
    opcode_40 = op; a_40 = a; b_40 = b; sign_ext_40 = se;
    src_reg_40 = RW'($urandom); dest_reg_40 = RW'($urandom); targ_reg_40 = RW'($urandom);
    in_valid_40 = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_40);
      ok = in_ready_40;
      @(posedge clk_40); #1;
    end
    in_valid_40 = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: opcode %b never accepted", op);
    end
  endtask

  logic [5:0] ops [13];

  initial begin
    ops = '{ADD, LDW, MUL, BLT, STW, BR, ADDI, BEQ, BNE, JMP, CALL, SUBI, NOPE};
    out_ready_40 = 1'b1;
    repeat (2) @(negedge clk_40);
    chk("rst_out_valid", out_valid_40, 0);
    chk("rst_in_ready", in_ready_40, 0);
    chk("rst_alu_out", alu_out_40, 0);
    chk("rst_flags", {opcode_out_40, branch_taken_40, illegal_op_40}, 0);
    rst_n_40 = 1'b1;
    @(posedge clk_40); #1;

    send(ADD, 5, 7, 0);
    @(negedge clk_40);
    chk("add_valid", out_valid_40, 1);
    chk("add_alu", alu_out_40, 12);
    chk("add_src", alu_src_40, 7);
    chk("add_op", opcode_out_40, 6'b110001);
    chk("add_taken", branch_taken_40, 0);
    @(posedge clk_40); #1;

    send(SUBI, 3, 0, 5);
    @(negedge clk_40); chk("subi_alu", alu_out_40, 32'hFFFF_FFFE);
    @(posedge clk_40); #1;
    send(BLT, 32'hFFFF_FFFF, 1, 0);
    @(negedge clk_40); chk("blt_taken", branch_taken_40, 1);
    @(posedge clk_40); #1;
    send(BEQ, 9, 9, 0);
    @(negedge clk_40); chk("beq_taken", branch_taken_40, 1);
    @(posedge clk_40); #1;
    send(BNE, 9, 9, 0);
    @(negedge clk_40); chk("bne_taken", branch_taken_40, 0);
    @(posedge clk_40); #1;

    // MUL: result lands MUL_LAT edges after accept, counting the accept edge
    send(MUL, 32'h0001_0000, 32'h0001_0003, 0);
    for (int k = 1; k < ML; k++) begin
      @(negedge clk_40);
      chk("mul_wait_valid", out_valid_40, 0);
      chk("mul_wait_ready", in_ready_40, 0);
    end
    @(negedge clk_40);
    chk("mul_valid", out_valid_40, 1);
    chk("mul_alu", alu_out_40, 32'h0003_0000);
    @(posedge clk_40); #1;

    // Backpressure
    send(ADD, 1, 1, 0);
    out_ready_40 = 1'b0;
    opcode_40 = ADD; a_40 = 2; b_40 = 2; in_valid_40 = 1'b1;
    repeat (3) begin
      @(negedge clk_40);
      chk("bp_hold_alu", alu_out_40, 2);
      chk("bp_hold_valid", out_valid_40, 1);
      chk("bp_in_ready", in_ready_40, 0);
      @(posedge clk_40); #1;
    end
    out_ready_40 = 1'b1;
    send(ADD, 2, 2, 0);
    @(negedge clk_40); chk("bp_next_alu", alu_out_40, 4);
    @(posedge clk_40); #1;

    // Flush during the 2nd MUL_BUSY cycle
    send(MUL, 3, 4, 0);
    @(posedge clk_40); #1;
    flush_40 = 1'b1;
    @(negedge clk_40); chk("flush_in_ready", in_ready_40, 0);
    @(posedge clk_40); #1;
    flush_40 = 1'b0;
    @(negedge clk_40);
    chk("flush_valid", out_valid_40, 0);
    chk("flush_ready_after", in_ready_40, 1);
    repeat (ML) begin
      @(negedge clk_40); chk("flush_no_stale", out_valid_40, 0);
    end
    @(posedge clk_40); #1;
    send(ADDI, 1, 0, 1);
    @(negedge clk_40);
    chk("addi_alu", alu_out_40, 2);
    chk("addi_valid", out_valid_40, 1);
    @(posedge clk_40); #1;

    // Illegal opcode
    send(6'b101010, 5, 6, 7);
    @(negedge clk_40);
    chk("ill_flag", illegal_op_40, 1);
    chk("ill_alu", alu_out_40, 0);
    chk("ill_op", opcode_out_40, 6'b101010);
    @(posedge clk_40); #1;

    // Reset mid-MUL
    send(ADD, 10, 20, 0);
    send(MUL, 7, 8, 0);
    @(posedge clk_40); #3;
    rst_n_40 = 1'b0;
    #1;
    chk("arst_alu", alu_out_40, 0);
    chk("arst_src", alu_src_40, 0);
    chk("arst_ctl", {out_valid_40, in_ready_40, opcode_out_40, branch_taken_40, illegal_op_40}, 0);
    @(negedge clk_40);
    @(negedge clk_40);
    #1 rst_n_40 = 1'b1;
    repeat (ML + 2) begin
      @(negedge clk_40); chk("arst_no_stale", out_valid_40, 0);
    end

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_40); #1;
      begin
        int idx;
        idx = int'($urandom % 16);
        opcode_40 = (idx < 13) ? ops[idx] : 6'($urandom);
      end
      a_40 = ($urandom % 4 == 0) ? DW'($urandom % 8) : DW'($urandom);
      b_40 = ($urandom % 3 == 0) ? a_40 : DW'($urandom);
      sign_ext_40 = DW'($urandom);
      src_reg_40 = RW'($urandom); dest_reg_40 = RW'($urandom); targ_reg_40 = RW'($urandom);
      in_valid_40 = ($urandom % 4) != 0;
      out_ready_40 = ($urandom % 4) != 0;
      flush_40 = ($urandom % 32) == 0;
    end
    @(posedge clk_40); #1;
    in_valid_40 = 1'b0;
    flush_40 = 1'b0;
    out_ready_40 = 1'b1;
    repeat (10) @(negedge clk_40);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
